// File: rtl/trace_packet_decoder.sv
// Trace packet decoder: turns address/timestamp/data packets into
// timestamped bus events behind a single skid-free output register.
module trace_packet_decoder #(
    parameter int TIME_W = 32
) (
    input  logic              mclk,
    input  logic              reset_n,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [1:0]        pkt_type,
    input  logic [22:0]       pkt_payload,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic              ev_write,
    output logic [22:0]       ev_addr,
    output logic [15:0]       ev_data,
    output logic [1:0]        ev_ublb,
    output logic [7:0]        ev_beat,
    output logic [TIME_W-1:0] ev_time,
    output logic              err_noaddr
);

    localparam logic [1:0] PKT_ADDR  = 2'b00;
    localparam logic [1:0] PKT_READ  = 2'b01;
    localparam logic [1:0] PKT_WRITE = 2'b10;
    localparam logic [1:0] PKT_TIME  = 2'b11;

    logic [22:0]       cur_addr_q, cur_addr_d;
    logic [7:0]        beat_q, beat_d;
    logic [TIME_W-1:0] time_acc_q, time_acc_d;
    logic              have_addr_q, have_addr_d;
    logic              err_noaddr_q, err_noaddr_d;
    logic              ev_valid_q, ev_valid_d;
    logic              ev_write_q, ev_write_d;
    logic [22:0]       ev_addr_q, ev_addr_d;
    logic [15:0]       ev_data_q, ev_data_d;
    logic [1:0]        ev_ublb_q, ev_ublb_d;
    logic [7:0]        ev_beat_q, ev_beat_d;
    logic [TIME_W-1:0] ev_time_q, ev_time_d;

    logic              accept;
    logic [TIME_W-1:0] data_time;

    // Ready is forced low while reset is held so no packet is lost.
    assign pkt_ready = reset_n && (!ev_valid_q || ev_ready);
    assign accept    = pkt_valid && pkt_ready;
    assign data_time = time_acc_q + TIME_W'(pkt_payload[22:18]);

    always_comb begin
        cur_addr_d   = cur_addr_q;
        beat_d       = beat_q;
        time_acc_d   = time_acc_q;
        have_addr_d  = have_addr_q;
        err_noaddr_d = err_noaddr_q;
        ev_valid_d   = ev_valid_q;
        ev_write_d   = ev_write_q;
        ev_addr_d    = ev_addr_q;
        ev_data_d    = ev_data_q;
        ev_ublb_d    = ev_ublb_q;
        ev_beat_d    = ev_beat_q;
        ev_time_d    = ev_time_q;

        if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end

        if (accept) begin
            unique case (pkt_type)
                PKT_ADDR: begin
                    cur_addr_d  = pkt_payload;
                    beat_d      = 8'd0;
                    have_addr_d = 1'b1;
                end
                PKT_TIME: begin
                    time_acc_d = time_acc_q + TIME_W'(pkt_payload);
                end
                PKT_READ, PKT_WRITE: begin
                    time_acc_d = data_time;
                    ev_valid_d = 1'b1;
                    ev_write_d = pkt_type[1];
                    ev_addr_d  = cur_addr_q;
                    ev_data_d  = pkt_payload[15:0];
                    ev_ublb_d  = pkt_payload[17:16];
                    ev_beat_d  = beat_q;
                    ev_time_d  = data_time;
                    cur_addr_d = cur_addr_q + 23'd1;
                    beat_d     = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
                    if (!have_addr_q) begin
                        err_noaddr_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr_q   <= '0;
            beat_q       <= '0;
            time_acc_q   <= '0;
            have_addr_q  <= 1'b0;
            err_noaddr_q <= 1'b0;
            ev_valid_q   <= 1'b0;
            ev_write_q   <= 1'b0;
            ev_addr_q    <= '0;
            ev_data_q    <= '0;
            ev_ublb_q    <= '0;
            ev_beat_q    <= '0;
            ev_time_q    <= '0;
        end else begin
            cur_addr_q   <= cur_addr_d;
            beat_q       <= beat_d;
            time_acc_q   <= time_acc_d;
            have_addr_q  <= have_addr_d;
            err_noaddr_q <= err_noaddr_d;
            ev_valid_q   <= ev_valid_d;
            ev_write_q   <= ev_write_d;
            ev_addr_q    <= ev_addr_d;
            ev_data_q    <= ev_data_d;
            ev_ublb_q    <= ev_ublb_d;
            ev_beat_q    <= ev_beat_d;
            ev_time_q    <= ev_time_d;
        end
    end

    assign ev_valid   = ev_valid_q;
    assign ev_write   = ev_write_q;
    assign ev_addr    = ev_addr_q;
    assign ev_data    = ev_data_q;
    assign ev_ublb    = ev_ublb_q;
    assign ev_beat    = ev_beat_q;
    assign ev_time    = ev_time_q;
    assign err_noaddr = err_noaddr_q;

endmodule

// File: doc/trace_packet_decoder.md
TRACE_PACKET_DECODER -- requirements
Module: trace_packet_decoder

Interface
REQ-001 Parameter TIME_W, default 32: width of the absolute timestamp accumulator and ev_time output.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset; mclk is the clock and reset_n is the reset.
REQ-003 Port mclk, input, 1 bit: 48 MHz clock; all state SHALL change on its rising edge.
REQ-004 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port pkt_valid, input, 1 bit: a trace packet is offered.
REQ-006 Port pkt_ready, output, 1 bit: the decoder accepts the packet this cycle.
REQ-007 Port pkt_type, input, 2 bits: 00 address, 01 read word, 10 write word, 11 timestamp.
REQ-008 Port pkt_payload, input, 23 bits: packet payload.
REQ-009 Port ev_valid, output, 1 bit: a decoded bus event is held.
REQ-010 Port ev_ready, input, 1 bit: the consumer takes the event.
REQ-011 Port ev_write, output, 1 bit: 1 for a write event, 0 for a read event.
REQ-012 Port ev_addr, output, 23 bits: word address of the event.
REQ-013 Port ev_data, output, 16 bits: data word.
REQ-014 Port ev_ublb, output, 2 bits: upper/lower byte strobes, copied from the packet.
REQ-015 Port ev_beat, output, 8 bits: data-beat index within the burst.
REQ-016 Port ev_time, output, TIME_W bits: absolute cycle time of the event.
REQ-017 Port err_noaddr, output, 1 bit: sticky flag; a data packet arrived before any address packet.

Function
REQ-018 Transfer rule: a packet SHALL be accepted when pkt_valid && pkt_ready.
REQ-019 pkt_ready SHALL equal !ev_valid || ev_ready for every packet type.
REQ-020 The output stage SHALL be a single register stage: on a data-packet accept, ev_* SHALL load on the next edge and ev_valid SHALL be 1.
REQ-021 On ev_valid && ev_ready with no new data packet accepted, ev_valid SHALL clear next cycle.
REQ-022 While ev_valid && !ev_ready, all ev_* outputs SHALL hold stable.
REQ-023 Internal state: cur_addr[22:0], beat[7:0], time_acc[TIME_W-1:0], and have_addr.
REQ-024 On an accepted address packet (00): cur_addr <= payload, beat <= 0, have_addr <= 1, time_acc unchanged, no event emitted.
REQ-025 On an accepted timestamp packet (11): time_acc <= time_acc + zero-extended payload[22:0], no event emitted.
REQ-026 For an accepted read (01) or write (10) packet, the payload fields SHALL be: ts5 = payload[22:18], ublb = payload[17:16], data = payload[15:0].
REQ-027 On an accepted read or write packet, time_acc <= time_acc + ts5.
REQ-028 The emitted event for a read or write packet SHALL be: ev_time = the new time_acc, ev_addr = cur_addr, ev_beat = beat, ev_write = pkt_type[1].
REQ-029 After a read or write packet, cur_addr <= cur_addr + 1, wrapping 7FFFFF -> 000000.
REQ-030 After a read or write packet, beat <= beat + 1, saturating at 255.
REQ-031 time_acc SHALL wrap modulo 2^TIME_W; no overflow flag.
REQ-032 A data packet accepted while have_addr == 0 SHALL still emit an event with ev_addr = cur_addr and SHALL set err_noaddr to 1.
REQ-033 err_noaddr SHALL clear only on reset.
REQ-034 A read burst and a write burst SHALL share cur_addr and beat; the type may change mid-burst without resetting the address.
REQ-035 A simultaneous event drain and data-packet accept SHALL load the new event with ev_valid staying 1, giving full throughput of one packet per cycle.

Reset
REQ-036 While reset_n == 0, the block SHALL reset asynchronously to: ev_valid 0, err_noaddr 0, have_addr 0, cur_addr 0, beat 0, time_acc 0, all ev_* data outputs 0.
REQ-037 While reset_n == 0, pkt_ready SHALL be 0.
REQ-038 A reset asserted mid-burst SHALL discard any held event and any partial burst state.

Verification
REQ-039 Stimulus: address 0x000100, then writes with ts5 = 3 and 2, data A5A5 and 5A5A, ev_ready = 1. Required: two events, addr 0x100 and 0x101, beat 0 and 1, ev_time 3 and 5, ev_write = 1.
REQ-040 Stimulus: timestamp payload 0x000040, then a read with ts5 = 31. Required: ev_time = 0x5F, ev_write = 0.
REQ-041 Stimulus: address 0x7FFFFF, then 3 reads. Required: ev_addr sequence 7FFFFF, 000000, 000001.
REQ-042 Stimulus: address, then 300 reads. Required: ev_beat counts 0..255, then holds at 255.
REQ-043 Stimulus: hold ev_ready = 0 with a pending event and pkt_valid = 1. Required: pkt_ready = 0 and outputs stable; on ev_ready = 1 with back-to-back packets, one event per cycle with no loss.
REQ-044 Stimulus: read packet before any address, then reset_n pulsed low mid-burst. Required: err_noaddr = 1, then ev_valid = 0, err_noaddr = 0, time_acc = 0 immediately.
